// File: rtl/div_fixed_seq.sv
// div_fixed_seq: restoring long division of a WIDTH-bit dividend by a constant DIVISOR,
// one quotient bit per clock, behind a start/busy/done handshake.
module div_fixed_seq #(
    parameter int WIDTH   = 16,
    parameter int DIVISOR = 185,
    localparam int R_W    = $clog2(DIVISOR + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [R_W-1:0]   r
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [R_W:0]     DIV_C    = (R_W + 1)'(DIVISOR);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    if (DIVISOR < 1) begin : g_bad_divisor
        $error("div_fixed_seq: DIVISOR must be >= 1");
    end

    logic [1:0]       state_r;
    logic [WIDTH-1:0] dvd_r;
    logic [R_W-1:0]   rem_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] q_r;
    logic [R_W-1:0]   r_r;

    logic [R_W:0]     rs_s;
    logic [R_W:0]     diff_s;
    logic             qbit_s;
    logic [R_W-1:0]   rem_nxt_s;
    logic [WIDTH-1:0] dvd_nxt_s;

    // One restoring step: the partial remainder stays below DIVISOR, so rs never overflows R_W+1 bits.
    always_comb begin
        rs_s   = {rem_r, dvd_r[WIDTH-1]};
        diff_s = rs_s - DIV_C;
        if (rs_s >= DIV_C) begin
            qbit_s    = 1'b1;
            rem_nxt_s = diff_s[R_W-1:0];
        end else begin
            qbit_s    = 1'b0;
            rem_nxt_s = rs_s[R_W-1:0];
        end
        dvd_nxt_s = {dvd_r[WIDTH-2:0], qbit_s};
    end

    // Control FSM, datapath registers and registered handshake/result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            dvd_r   <= {WIDTH{1'b0}};
            rem_r   <= {R_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            q_r     <= {WIDTH{1'b0}};
            r_r     <= {R_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r <= ST_RUN;
                        dvd_r   <= a;
                        rem_r   <= {R_W{1'b0}};
                        cnt_r   <= CNT_LAST;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    dvd_r <= dvd_nxt_s;
                    rem_r <= rem_nxt_s;
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        q_r     <= dvd_nxt_s;
                        r_r     <= rem_nxt_s;
                    end else begin
                        cnt_r <= cnt_r - 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign q    = q_r;
    assign r    = r_r;

endmodule

// File: tb/tb_div_fixed_seq.sv
// Bench for div_fixed_seq: directed vectors with literal results plus random traffic,
// all cross-checked every cycle against a latency/arithmetic reference model.
module tb_div_fixed_seq;
    localparam int WIDTH   = 16;
    localparam int DIVISOR = 185;
    localparam int R_W     = $clog2(DIVISOR + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    logic [R_W-1:0]   r;

    int n_checks = 0;
    int n_pass   = 0;

    div_fixed_seq #(.WIDTH(WIDTH), .DIVISOR(DIVISOR)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a),
        .busy(busy), .done(done), .q(q), .r(r)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model: an accepted request yields a/DIVISOR and a%DIVISOR WIDTH+1 edges later.
    bit m_busy = 1'b0;
    bit m_done = 1'b0;
    int m_left = 0;
    int m_q = 0, m_r = 0, pq = 0, pr = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0; m_q <= 0; m_r <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy <= 1'b0; m_done <= 1'b1; m_q <= pq; m_r <= pr;
                end
            end else if (start) begin
                m_busy <= 1'b1;
                m_left <= WIDTH;
                pq     <= int'(a) / DIVISOR;
                pr     <= int'(a) % DIVISOR;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("q", q, m_q);
            check("r", r, m_r);
        end
    end

    // Called at a negedge; launches one request and waits for its done pulse.
    // intrude>0 raises a stray start that many cycles into the run.
    task automatic run_op(input int av, input int intrude, input string tag);
        int edges;
        start = 1'b1;
        a     = WIDTH'(av);
        @(negedge clk);
        edges = 1;
        while (!done && edges < 40) begin
            if (edges == intrude) begin
                start = 1'b1;
                a     = WIDTH'($urandom_range(0, 65535));
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            edges++;
        end
        start = 1'b0;
        check({tag, "_latency"}, edges, WIDTH + 1);
        check({tag, "_q"}, q, av / DIVISOR);
        check({tag, "_r"}, r, av % DIVISOR);
    endtask

    task automatic count_done(input int cycles, input string tag);
        int pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check(tag, pulses, 0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_q", q, 0);
        check("rst_r", r, 0);
        rst = 1'b0;
        @(negedge clk);

        run_op(23495, 0, "exact");
        check("exact_q_lit", q, 127);
        check("exact_r_lit", r, 0);
        @(negedge clk);
        run_op(65535, 0, "max");
        check("max_q_lit", q, 354);
        check("max_r_lit", r, 45);
        run_op(0, 0, "zero");
        check("zero_q_lit", q, 0);
        run_op(184, 0, "d184");
        check("d184_r_lit", r, 184);
        run_op(185, 0, "d185");
        check("d185_q_lit", q, 1);
        run_op(186, 0, "d186");
        check("d186_r_lit", r, 1);

        @(negedge clk);
        run_op(23495, 5, "busy_start");
        check("busy_start_q_lit", q, 127);
        run_op(370, 0, "b2b");
        check("b2b_q_lit", q, 2);
        check("b2b_r_lit", r, 0);
        count_done(20, "busy_start_single_done");

        start = 1'b1;
        a     = 16'd40000;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_q", q, 0);
        check("abort_r", r, 0);
        count_done(30, "abort_no_done");

        for (int i = 0; i < 1500; i++) begin
            int av, gap, intr;
            av   = (i < 400) ? i : int'($urandom_range(0, 65535));
            gap  = int'($urandom_range(0, 2));
            intr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 16)) : 0;
            repeat (gap) @(negedge clk);
            run_op(av, intr, "rand");
        end

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
